// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Parallel-to-serial stage. Accepts WIDTH-bit words over a
//            valid/ready handshake and shifts them out one bit per bit_en
//            strobe on dout. Back-to-back words are joined with no idle gap
//            so a downstream bit-pattern detector sees a continuous stream.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            in_valid   - upstream word available
//            in_data    - word to serialize, sampled only on accept
//            in_ready   - word can be accepted this cycle (combinational)
//            bit_en     - bit-rate strobe, one bit advance per high cycle
//            dout       - serial bit (registered)
//            dout_valid - dout carries a data bit (registered)
//            last       - dout carries the final bit of a word (registered)
//            busy       - a word is being shifted
// Revision : 1.0 - initial release
// ============================================================================
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             bit_en,
    output logic             dout,
    output logic             dout_valid,
    output logic             last,
    output logic             busy
);

    localparam int              C_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [C_CW-1:0] C_LAST = C_CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [C_CW-1:0]  r_cnt;
    logic             r_dout;
    logic             r_dout_valid;
    logic             r_last;

    logic             w_final;
    logic             w_accept;
    logic             w_first_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_shift_rest;

    // The final bit of the current word ends on this edge.
    assign w_final  = (r_state == S_SHIFT) & bit_en & (r_cnt == C_LAST);
    assign in_ready = reset_n & ((r_state == S_IDLE) | w_final);
    assign w_accept = in_valid & in_ready;

    // The shift register holds only the bits not yet presented on dout,
    // aligned so the next bit is always at the outgoing end.
    assign w_first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
    assign w_load_rest  = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0}
                                    : {1'b0, in_data[WIDTH-1:1]};
    assign w_next_bit   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shift_rest = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                    : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_dout       <= IDLE_BIT;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
        end else if (w_accept) begin
            // Covers both the idle load and the zero-gap reload on the
            // final bit; bit_en does not gate an idle load.
            r_state      <= S_SHIFT;
            r_shreg      <= w_load_rest;
            r_cnt        <= '0;
            r_dout       <= w_first_bit;
            r_dout_valid <= 1'b1;
            r_last       <= 1'b0;
        end else if ((r_state == S_SHIFT) && bit_en) begin
            if (r_cnt != C_LAST) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shreg <= w_shift_rest;
                r_dout  <= w_next_bit;
                r_last  <= ((r_cnt + 1'b1) == C_LAST);
            end else begin
                r_state      <= S_IDLE;
                r_dout       <= IDLE_BIT;
                r_dout_valid <= 1'b0;
                r_last       <= 1'b0;
            end
        end else if (r_state == S_IDLE) begin
            r_dout       <= IDLE_BIT;
            r_dout_valid <= 1'b0;
            r_last       <= 1'b0;
        end
        // SHIFT with bit_en low: everything holds, stretching the bit.
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign last       = r_last;
    assign busy       = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Self-checking bench for bit_serializer. One MSB-first and one
//            LSB-first instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       bit_en;

    logic m_rdy, m_dout, m_dv, m_last, m_busy;
    logic l_rdy, l_dout, l_dv, l_last, l_busy;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(m_rdy), .bit_en(bit_en), .dout(m_dout), .dout_valid(m_dv),
        .last(m_last), .busy(m_busy)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(l_rdy), .bit_en(bit_en), .dout(l_dout), .dout_valid(l_dv),
        .last(l_last), .busy(l_busy)
    );

    typedef struct {
        logic       iv;
        logic [7:0] data;
        logic       be;
        logic       rdy;   // in_ready before the edge
        logic       dout;  // registered outputs after the edge
        logic       dv;
        logic       last;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [7:0] data,
                                input logic be, input logic rdy,
                                input logic dout, input logic dv,
                                input logic last, input logic busy);
        vec_t v;
        v.iv = iv; v.data = data; v.be = be; v.rdy = rdy;
        v.dout = dout; v.dv = dv; v.last = last; v.busy = busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        in_valid = v.iv;
        in_data  = v.data;
        bit_en   = v.be;
        #1;
        chk({name, "/in_ready"}, m_rdy, v.rdy);
        @(posedge clk); #1;
        chk({name, "/dout"},       m_dout, v.dout);
        chk({name, "/dout_valid"}, m_dv,   v.dv);
        chk({name, "/last"},       m_last, v.last);
        chk({name, "/busy"},       m_busy, v.busy);
    endtask

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        int         b;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        bit_en   = 1'b1;

        // ---------------- Reset state and mid-cycle release ----------------
        #2;
        chk("rst/dout", m_dout, 1'b0);
        chk("rst/dv",   m_dv,   1'b0);
        chk("rst/last", m_last, 1'b0);
        chk("rst/busy", m_busy, 1'b0);
        chk("rst/rdy",  m_rdy,  1'b0);
        @(posedge clk); @(posedge clk); #3;
        reset_n = 1'b1;
        #1;
        chk("rel/rdy",  m_rdy,  1'b1);
        chk("rel/busy", m_busy, 1'b0);
        @(posedge clk); #1;

        // ---------------- Single word 0xA5, MSB first ----------------
        vecs.push_back(mk(1, 8'hA5, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0));
        // ---------------- Back-to-back 0x05 then 0xA0 ----------------
        vecs.push_back(mk(1, 8'h05, 1, 1, 0, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 8'hA0, 1, 1, 1, 1, 0, 1)); // zero-gap reload
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---------------- LSB first, 0x01 ----------------
        w = 8'h01;
        in_valid = 1'b1; in_data = w; bit_en = 1'b1;
        #1;
        chk("lsb/rdy", l_rdy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = 8'h00;
            chk($sformatf("lsb/dout%0d", k), l_dout, w[k]);
            chk($sformatf("lsb/dv%0d", k),   l_dv,   1'b1);
            chk($sformatf("lsb/last%0d", k), l_last, (k == 7));
        end
        @(posedge clk); #1;
        chk("lsb/end_dv",   l_dv,   1'b0);
        chk("lsb/end_busy", l_busy, 1'b0);

        // ---------------- Gated bit_en, 0xF0, one strobe every 3rd cycle ----
        w = 8'hF0;
        in_valid = 1'b1; in_data = w; bit_en = 1'b0;
        #1;
        chk("gate/rdy0", m_rdy, 1'b1);
        @(posedge clk); #1;
        chk("gate/first", m_dout, w[7]);
        chk("gate/first_dv", m_dv, 1'b1);
        in_valid = 1'b0; in_data = 8'h00;
        b = 0;
        for (int j = 1; j < 40 && b < 8; j++) begin
            bit_en = (j % 3 == 0);
            #1;
            chk($sformatf("gate/rdy_j%0d", j), m_rdy, (b == 7) && bit_en);
            @(posedge clk); #1;
            if (bit_en) b++;
            if (b < 8) begin
                chk($sformatf("gate/dout_j%0d", j), m_dout, w[7-b]);
                chk($sformatf("gate/dv_j%0d", j),   m_dv,   1'b1);
                chk($sformatf("gate/last_j%0d", j), m_last, (b == 7));
            end else begin
                chk("gate/end_dv",   m_dv,   1'b0);
                chk("gate/end_busy", m_busy, 1'b0);
            end
        end
        if (b != 8) begin
            n_total++;
            $display("FAIL gate/bound: bits seen %0d expected 8", b);
        end

        // ---------------- Reset mid-word after 3 bits of 0xFF ----------------
        bit_en = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        chk("abort/pre_busy", m_busy, 1'b1);
        chk("abort/pre_dout", m_dout, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort/dout", m_dout, 1'b0);
        chk("abort/dv",   m_dv,   1'b0);
        chk("abort/last", m_last, 1'b0);
        chk("abort/busy", m_busy, 1'b0);
        chk("abort/rdy",  m_rdy,  1'b0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("abort/idle_dv", m_dv, 1'b0);
        w = 8'h81;
        in_valid = 1'b1; in_data = w;
        #1;
        chk("resend/rdy", m_rdy, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0; in_data = 8'h00;
            chk($sformatf("resend/dout%0d", k), m_dout, w[7-k]);
            chk($sformatf("resend/dv%0d", k),   m_dv,   1'b1);
            chk($sformatf("resend/last%0d", k), m_last, (k == 7));
        end
        @(posedge clk); #1;
        chk("resend/end_dv",   m_dv,   1'b0);
        chk("resend/end_dout", m_dout, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
